// File: rtl/p_array_pkg.sv
// Shared definitions for the 4-lane processor array drain side.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   LP_N_LANES / LP_DATA_W : default lane count and lane result width
//   lane_idx_t             : lane index (0 = P1)
//   coll_state_t           : result-collector FSM states
//   clamp_lanes()          : MAT_SIZE -> number of active lanes (0..N_LANES)
package p_array_pkg;

   localparam int LP_N_LANES = 4;
   localparam int LP_DATA_W  = 16;

   typedef logic [1:0] lane_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } coll_state_t;

   // MAT_SIZE is 4 bits wide but the array only has LP_N_LANES lanes, so
   // anything larger is treated as "all lanes".
   function automatic logic [2:0] clamp_lanes(input logic [3:0] mat_size);
      if (mat_size > 4'(LP_N_LANES)) begin
         return 3'(LP_N_LANES);
      end
      return mat_size[2:0];
   endfunction

endpackage

// File: rtl/p_lane_hold.sv
// Per-lane result holding register with a full flag and overflow detect.
// Latency: capture pulse -> o_full/o_data updated after one edge.
// Backpressure: none; a capture while full (and not being cleared) is dropped and flagged on o_ovf.
//
// Ports:
//   clk, rst      : clock, async active-low reset
//   i_flush       : synchronous clear of data and full flag (session abort)
//   i_lane_en     : lane participates in the current session and capture is allowed
//   i_capture     : one-cycle completion pulse from the lane
//   i_clear       : collector is taking the held result on this edge
//   i_data        : lane result
//   o_data/o_full : held result and its valid flag
//   o_ovf         : combinational, a capture is being dropped on this edge
module p_lane_hold
   import p_array_pkg::*;
#(
   parameter int DATA_W = LP_DATA_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_lane_en,
   input  logic              i_capture,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_ovf
);

   logic [DATA_W-1:0] r_data;
   logic              r_full;
   logic              w_cap_ok;

   // A new result fits if the slot is empty, or if the current one is being
   // taken by the collector on this very edge.
   assign w_cap_ok = i_lane_en & i_capture & (~r_full | i_clear);
   assign o_ovf    = i_lane_en & i_capture & r_full & ~i_clear;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (i_flush) begin
         r_data <= '0;
         r_full <= 1'b0;
      end else if (w_cap_ok) begin
         r_data <= i_data;
         r_full <= 1'b1;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   assign o_data = r_data;
   assign o_full = r_full;

endmodule

// File: rtl/p_result_collect.sv
// Collects per-lane results and serialises them in lane order onto one valid/ready stream.
// Latency: lane pulse at edge N (lane being waited on) -> OUT_VALID from edge N+2; at best one result per 2 cycles.
// Backpressure: OUT_DATA/OUT_IDX held stable while OUT_VALID & !OUT_READY; lanes buffer one result each.
//
// Ports:
//   clk, rst            : clock, async active-low reset
//   Enable              : session enable; low clears everything on the next edge
//   MAT_SIZE            : number of active lanes, sampled when leaving IDLE
//   RES_VALID/RES_DATA  : per-lane completion pulse and result (lane i at [i*DATA_W +: DATA_W])
//   OUT_DATA/OUT_IDX    : serialised result and its lane index
//   OUT_VALID/OUT_READY : output handshake
//   DONE                : all active lanes delivered (held until Enable low)
//   OVF_ERR             : sticky, a lane result was dropped because its slot was still occupied
module p_result_collect
   import p_array_pkg::*;
#(
   parameter int N_LANES = LP_N_LANES,
   parameter int DATA_W  = LP_DATA_W
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      Enable,
   input  logic [3:0]                MAT_SIZE,
   input  logic [N_LANES-1:0]        RES_VALID,
   input  logic [N_LANES*DATA_W-1:0] RES_DATA,
   output logic [DATA_W-1:0]         OUT_DATA,
   output logic [1:0]                OUT_IDX,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic                      DONE,
   output logic                      OVF_ERR
);

   coll_state_t       r_state;
   coll_state_t       w_next_state;
   logic [2:0]        r_cnt;
   lane_idx_t         r_idx;
   logic [DATA_W-1:0] r_out_data;
   lane_idx_t         r_out_idx;
   logic              r_out_valid;
   logic              r_done;
   logic              r_ovf;

   logic [2:0]        w_cnt_new;
   logic              w_active;
   logic              w_last;
   logic              w_take;
   logic              w_idx_inc;
   logic [N_LANES-1:0] w_lane_en;
   logic [N_LANES-1:0] w_clear;
   logic [N_LANES-1:0] w_full;
   logic [N_LANES-1:0] w_ovf;
   logic [DATA_W-1:0]  w_hold [N_LANES];

   assign w_cnt_new = clamp_lanes(MAT_SIZE);

   // Lanes only capture while the collector is actually draining; in IDLE
   // the lane count is not known yet and in DONE late pulses are ignored.
   assign w_active  = (r_state == ST_WAIT) || (r_state == ST_SEND);

   // r_cnt >= 1 whenever the FSM can be in SEND, so the subtraction is safe.
   assign w_last    = ({1'b0, r_idx} == (r_cnt - 3'd1));

   //---------------------------------------------------------------------
   // Per-lane holding registers
   //---------------------------------------------------------------------
   for (genvar g = 0; g < N_LANES; g++) begin : g_lane
      assign w_lane_en[g] = w_active & (3'(g) < r_cnt);
      assign w_clear[g]   = w_take & (r_idx == lane_idx_t'(g));

      p_lane_hold #(
         .DATA_W (DATA_W)
      ) u_hold (
         .clk       (clk),
         .rst       (rst),
         .i_flush   (~Enable),
         .i_lane_en (w_lane_en[g]),
         .i_capture (RES_VALID[g]),
         .i_clear   (w_clear[g]),
         .i_data    (RES_DATA[g*DATA_W +: DATA_W]),
         .o_data    (w_hold[g]),
         .o_full    (w_full[g]),
         .o_ovf     (w_ovf[g])
      );
   end

   //---------------------------------------------------------------------
   // FSM next state
   //---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_take       = 1'b0;
      w_idx_inc    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_next_state = (w_cnt_new == 3'd0) ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            if (w_full[r_idx]) begin
               w_next_state = ST_SEND;
               w_take       = 1'b1;
            end
         end
         ST_SEND: begin
            // OUT_VALID is high for the whole of SEND, so READY alone
            // completes the handshake here.
            if (OUT_READY) begin
               if (w_last) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_WAIT;
                  w_idx_inc    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_next_state = ST_DONE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
      if (!Enable) begin
         w_next_state = ST_IDLE;
         w_take       = 1'b0;
         w_idx_inc    = 1'b0;
      end
   end

   //---------------------------------------------------------------------
   // State, index and output registers
   //---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (!Enable) begin
         // Abort: in-flight output is dropped without a handshake.
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_IDLE) begin
            r_cnt <= w_cnt_new;
         end
         if (w_take) begin
            r_out_data <= w_hold[r_idx];
            r_out_idx  <= r_idx;
         end
         if (w_idx_inc) begin
            r_idx <= r_idx + 2'd1;
         end
         // Decoding the next state keeps OUT_VALID/DONE registered yet
         // exactly aligned with the state register.
         r_out_valid <= (w_next_state == ST_SEND);
         r_done      <= (w_next_state == ST_DONE);
         if (|w_ovf) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign OUT_DATA  = r_out_data;
   assign OUT_IDX   = r_out_idx;
   assign OUT_VALID = r_out_valid;
   assign DONE      = r_done;
   assign OVF_ERR   = r_ovf;

endmodule

// File: tb/tb_p_result_collect.sv
// Self-checking bench for p_result_collect: directed scenarios plus randomized sessions.
// Each session drives a schedule of lane pulses and records every output handshake.
// Expected beats come from a lane-order model built from the pulse schedule.
module tb_p_result_collect;
   import p_array_pkg::*;

   localparam int NL = 4;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             Enable;
   logic [3:0]       MAT_SIZE;
   logic [NL-1:0]    RES_VALID;
   logic [NL*DW-1:0] RES_DATA;
   logic [DW-1:0]    OUT_DATA;
   logic [1:0]       OUT_IDX;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic             DONE;
   logic             OVF_ERR;

   p_result_collect #(.N_LANES(NL), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .Enable    (Enable),
      .MAT_SIZE  (MAT_SIZE),
      .RES_VALID (RES_VALID),
      .RES_DATA  (RES_DATA),
      .OUT_DATA  (OUT_DATA),
      .OUT_IDX   (OUT_IDX),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .DONE      (DONE),
      .OVF_ERR   (OVF_ERR)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         cyc;
      int         lane;
      logic [15:0] data;
   } ev_t;

   typedef struct packed {
      logic [1:0]  idx;
      logic [15:0] data;
   } beat_t;

   ev_t   evq[$];
   beat_t beats[$];
   beat_t expq[$];

   int first_valid, done_cycle, done_beats, stab_err, timed_out;
   int ready_mode;   // 0 always, 1 random, 2 stall 3 cycles per beat, 3 ready from cycle ready_from
   int ready_from;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_ev(input int cyc, input int lane, input logic [15:0] data);
      ev_t e;
      e.cyc = cyc; e.lane = lane; e.data = data;
      evq.push_back(e);
   endtask

   // Model: active lanes are min(ms,4); each delivers, in lane order, the
   // first result it reported (later ones while still full are dropped).
   task automatic build_exp(input logic [3:0] ms);
      int    cnt;
      int    best;
      beat_t b;
      expq.delete();
      cnt = (ms > 4'd4) ? 4 : int'(ms);
      for (int l = 0; l < cnt; l++) begin
         best = -1;
         foreach (evq[j])
            if (evq[j].lane == l && (best < 0 || evq[j].cyc < evq[best].cyc)) best = j;
         if (best >= 0) begin
            b.idx  = l[1:0];
            b.data = evq[best].data;
            expq.push_back(b);
         end
      end
   endtask

   // Runs one session: clear, raise Enable in cycle 0, play the schedule,
   // record handshakes; stops once DONE is seen and the schedule is played.
   task automatic run_session(input logic [3:0] ms, input int max_cyc);
      int          stall, last_ev;
      logic        pv, pr;
      logic [15:0] pd;
      logic [1:0]  pi;
      beat_t       b;
      beats.delete();
      first_valid = -1; done_cycle = -1; done_beats = -1; stab_err = 0; timed_out = 0;
      last_ev = 0;
      foreach (evq[j]) if (evq[j].cyc > last_ev) last_ev = evq[j].cyc;
      Enable = 1'b0; RES_VALID = '0; OUT_READY = 1'b0;
      tick();
      MAT_SIZE = ms; Enable = 1'b1;
      stall = 0; pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
      for (int k = 0; ; k++) begin
         if (k >= max_cyc) begin
            timed_out = 1;
            break;
         end
         if (pv && !pr && (!OUT_VALID || OUT_DATA !== pd || OUT_IDX !== pi)) stab_err++;
         if (OUT_VALID && first_valid < 0) first_valid = k;
         if (DONE && done_cycle < 0) begin
            done_cycle = k;
            done_beats = beats.size();
         end
         if (done_cycle >= 0 && k > last_ev) break;
         case (ready_mode)
            0: OUT_READY = 1'b1;
            1: OUT_READY = 1'($urandom % 2);
            2: begin
               if (OUT_VALID) begin
                  if (stall < 3) begin OUT_READY = 1'b0; stall++; end
                  else begin OUT_READY = 1'b1; stall = 0; end
               end else OUT_READY = 1'b0;
            end
            default: OUT_READY = (k >= ready_from);
         endcase
         if (OUT_VALID && OUT_READY) begin
            b.idx = OUT_IDX; b.data = OUT_DATA;
            beats.push_back(b);
         end
         pv = OUT_VALID; pr = OUT_READY; pd = OUT_DATA; pi = OUT_IDX;
         RES_VALID = '0;
         foreach (evq[j]) if (evq[j].cyc == k) begin
            RES_VALID[evq[j].lane] = 1'b1;
            RES_DATA[evq[j].lane*DW +: DW] = evq[j].data;
         end
         tick();
      end
      RES_VALID = '0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", OUT_VALID); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
      checks++; if (OVF_ERR !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", OVF_ERR); end
      checks++; if (OUT_DATA !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", OUT_DATA); end
      checks++; if (OUT_IDX !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", OUT_IDX); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_in_order();
      evq.delete();
      add_ev(1, 0, 16'h0011); add_ev(2, 1, 16'h0022); add_ev(3, 2, 16'h0033); add_ev(4, 3, 16'h0044);
      ready_mode = 0;
      run_session(4'd4, 100);
      build_exp(4'd4);
      checks++; if (timed_out !== 0) begin errors++; $display("FAIL inorder_timeout got %0d want 0", timed_out); end
      checks++; if (beats.size() !== 4) begin errors++; $display("FAIL inorder_count got %0d want 4", beats.size()); end
      foreach (expq[i]) if (i < beats.size()) begin
         checks++;
         if (beats[i] !== expq[i]) begin errors++; $display("FAIL inorder_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
      end
      checks++; if (first_valid !== 3) begin errors++; $display("FAIL inorder_latency got cycle %0d want 3", first_valid); end
      checks++; if (done_beats !== 4) begin errors++; $display("FAIL inorder_done_beats got %0d want 4", done_beats); end
      checks++; if (OVF_ERR !== 1'b0) begin errors++; $display("FAIL inorder_ovf got %b want 0", OVF_ERR); end
   endtask

   task automatic test_out_of_order();
      evq.delete();
      add_ev(1, 2, 16'h000C); add_ev(2, 0, 16'h000A); add_ev(3, 1, 16'h000B);
      ready_mode = 2;
      run_session(4'd3, 200);
      build_exp(4'd3);
      checks++; if (beats.size() !== 3) begin errors++; $display("FAIL ooo_count got %0d want 3", beats.size()); end
      foreach (expq[i]) if (i < beats.size()) begin
         checks++;
         if (beats[i] !== expq[i]) begin errors++; $display("FAIL ooo_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
      end
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL ooo_stable got %0d changes want 0", stab_err); end
      checks++; if (done_beats !== 3) begin errors++; $display("FAIL ooo_done_beats got %0d want 3", done_beats); end
   endtask

   task automatic test_clamp();
      evq.delete();
      add_ev(3, 0, 16'h0099);
      ready_mode = 0;
      run_session(4'd0, 50);
      checks++; if (done_cycle !== 1) begin errors++; $display("FAIL clamp0_done got cycle %0d want 1", done_cycle); end
      checks++; if (first_valid !== -1) begin errors++; $display("FAIL clamp0_valid got cycle %0d want none", first_valid); end

      evq.delete();
      add_ev(2, 3, 16'h0D0D); add_ev(3, 1, 16'h0B0B); add_ev(4, 0, 16'h0A0A); add_ev(5, 2, 16'h0C0C);
      run_session(4'd9, 100);
      build_exp(4'd9);
      checks++; if (beats.size() !== 4) begin errors++; $display("FAIL clamp9_count got %0d want 4", beats.size()); end
      foreach (expq[i]) if (i < beats.size()) begin
         checks++;
         if (beats[i] !== expq[i]) begin errors++; $display("FAIL clamp9_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
      end

      evq.delete();
      add_ev(1, 3, 16'h3333); add_ev(2, 0, 16'h1111); add_ev(3, 1, 16'h2222);
      run_session(4'd2, 100);
      build_exp(4'd2);
      checks++; if (beats.size() !== 2) begin errors++; $display("FAIL clamp2_count got %0d want 2", beats.size()); end
      foreach (expq[i]) if (i < beats.size()) begin
         checks++;
         if (beats[i] !== expq[i]) begin errors++; $display("FAIL clamp2_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
      end
      checks++; if (done_beats !== 2) begin errors++; $display("FAIL clamp2_done_beats got %0d want 2", done_beats); end
      checks++; if (OVF_ERR !== 1'b0) begin errors++; $display("FAIL clamp2_ovf got %b want 0", OVF_ERR); end
   endtask

   task automatic test_overflow();
      evq.delete();
      add_ev(1, 1, 16'h0005); add_ev(3, 1, 16'h0006); add_ev(5, 0, 16'h00F0);
      ready_mode = 3; ready_from = 10;
      run_session(4'd2, 100);
      build_exp(4'd2);
      checks++; if (OVF_ERR !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", OVF_ERR); end
      checks++; if (beats.size() !== 2) begin errors++; $display("FAIL ovf_count got %0d want 2", beats.size()); end
      foreach (expq[i]) if (i < beats.size()) begin
         checks++;
         if (beats[i] !== expq[i]) begin errors++; $display("FAIL ovf_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
      end
   endtask

   task automatic test_abort();
      evq.delete();
      add_ev(1, 0, 16'h1234); add_ev(2, 1, 16'h5678); add_ev(3, 2, 16'h9ABC); add_ev(4, 2, 16'hDEAD);
      ready_mode = 3; ready_from = 1000;
      run_session(4'd4, 8);
      checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got %b want 1", OUT_VALID); end
      checks++; if (OVF_ERR !== 1'b1) begin errors++; $display("FAIL abort_pre_ovf got %b want 1", OVF_ERR); end
      Enable = 1'b0;
      tick();
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", OUT_VALID); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", DONE); end
      checks++; if (OVF_ERR !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", OVF_ERR); end

      evq.delete();
      add_ev(4, 0, 16'h0A0A); add_ev(5, 1, 16'h0B0B);
      ready_mode = 0;
      run_session(4'd2, 100);
      build_exp(4'd2);
      checks++; if (first_valid !== 6) begin errors++; $display("FAIL restart_latency got cycle %0d want 6", first_valid); end
      checks++; if (beats.size() !== 2) begin errors++; $display("FAIL restart_count got %0d want 2", beats.size()); end
      foreach (expq[i]) if (i < beats.size()) begin
         checks++;
         if (beats[i] !== expq[i]) begin errors++; $display("FAIL restart_beat%0d got idx=%0d data=%h want idx=%0d data=%h", i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
      end
      checks++; if (OVF_ERR !== 1'b0) begin errors++; $display("FAIL restart_ovf got %b want 0", OVF_ERR); end
   endtask

   task automatic test_async_reset();
      evq.delete();
      add_ev(1, 1, 16'h0055); add_ev(2, 1, 16'h0066);
      ready_mode = 0;
      run_session(4'd2, 5);
      checks++; if (OVF_ERR !== 1'b1) begin errors++; $display("FAIL arst_pre_ovf got %b want 1", OVF_ERR); end
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if ({OUT_VALID, DONE, OVF_ERR, OUT_IDX, OUT_DATA} !== 21'd0) begin
         errors++;
         $display("FAIL arst_outputs got valid=%b done=%b ovf=%b idx=%0d data=%h want all 0", OUT_VALID, DONE, OVF_ERR, OUT_IDX, OUT_DATA);
      end
      #2;
      Enable = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic [3:0] ms;
      for (int it = 0; it < 8; it++) begin
         evq.delete();
         ms = 4'($urandom_range(0, 15));
         for (int l = 0; l < NL; l++) add_ev($urandom_range(1, 12), l, 16'($urandom));
         ready_mode = 1;
         run_session(ms, 300);
         build_exp(ms);
         checks++; if (timed_out !== 0) begin errors++; $display("FAIL rand%0d_timeout got %0d want 0", it, timed_out); end
         checks++; if (beats.size() !== expq.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, beats.size(), expq.size()); end
         foreach (expq[i]) if (i < beats.size()) begin
            checks++;
            if (beats[i] !== expq[i]) begin errors++; $display("FAIL rand%0d_beat%0d got idx=%0d data=%h want idx=%0d data=%h", it, i, beats[i].idx, beats[i].data, expq[i].idx, expq[i].data); end
         end
         checks++; if (done_beats !== expq.size()) begin errors++; $display("FAIL rand%0d_done_beats got %0d want %0d", it, done_beats, expq.size()); end
         checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand%0d_stable got %0d changes want 0", it, stab_err); end
         checks++; if (OVF_ERR !== 1'b0) begin errors++; $display("FAIL rand%0d_ovf got %b want 0", it, OVF_ERR); end
      end
   endtask

   initial begin
      rst = 1'b0; Enable = 1'b0; MAT_SIZE = '0; RES_VALID = '0; RES_DATA = '0; OUT_READY = 1'b0;
      ready_mode = 0; ready_from = 0;
      test_reset();
      test_in_order();
      test_out_of_order();
      test_clamp();
      test_overflow();
      test_abort();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
